// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: access-size codes,
// controller state encoding and the alignment rule.
package lsu_pkg;

    // Access size codes as presented on the size port.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // A halfword must sit on an even address, a word on a multiple of four.
    // Bytes are never misaligned; the illegal size code is rejected elsewhere.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (sz)
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ctrl_lane_mux.sv
// Lane select logic shared by the load and store paths: extracts and
// extends a byte/half/word from a RAM word, and merges store data into a
// buffered RAM word for read-modify-write.
import lsu_pkg::*;

module lane_mux #(
    parameter int LITTLE_END = 1
) (
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [31:0] buf_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    // Physical lane index. Only little-endian numbering is a supported
    // configuration; the inverted form just keeps the parameter meaningful.
    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_en;
    logic [31:0] ins_word;

    assign lane = (LITTLE_END != 0) ? byte_off : ~byte_off;

    // Load side: pick the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_sel  = rd_word[{lane, 3'b000} +: 8];
        half_sel  = rd_word[{lane[1], 4'b0000} +: 16];
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Store side: choose which byte lanes take new data; store data is
    // replicated across lanes so each lane can just pick its own slice.
    always_comb begin
        lane_en  = 4'b1111;
        ins_word = wdata;
        case (size)
            SZ_BYTE: begin
                lane_en  = 4'b0001 << lane;
                ins_word = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_en  = lane[1] ? 4'b1100 : 4'b0011;
                ins_word = {2{wdata[15:0]}};
            end
            default: begin
                lane_en  = 4'b1111;
                ins_word = wdata;
            end
        endcase
    end

    // Per-lane merge: enabled lanes take the store data, others keep RAM data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merge_data[8*gi +: 8] = lane_en[gi] ? ins_word[8*gi +: 8]
                                                   : buf_word[8*gi +: 8];
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller sitting between the multicycle core and a
// single-port word RAM (combinational read, clocked write). Handles
// sub-word loads with extension and sub-word stores via read-modify-write.
import lsu_pkg::*;

module lsu_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int LITTLE_END  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we_in,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout
);

    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // A request is rejected before touching the RAM if its size is illegal,
    // it is misaligned for its size, or its word index is past the RAM.
    assign req_fault = (size == SZ_ILL)
                     | is_misaligned(size, addr[1:0])
                     | (addr[31:2] >= DEPTH_LIM);

    lane_mux #(
        .LITTLE_END (LITTLE_END)
    ) u_lane_mux (
        .size       (size_q),
        .sign_ext   (sext_q),
        .byte_off   (addr_q[1:0]),
        .rd_word    (ram_dout),
        .buf_word   (buf_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state logic and request latching; every register holds by default.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we_in;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = req_fault;
                    if (req_fault) begin
                        state_d = ST_FIN;
                    end else if (we_in && (size == SZ_WORD)) begin
                        // Full-word stores need no read: merge covers all lanes.
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    buf_d   = ram_dout;
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_FIN;
                end
            end
            ST_WR: begin
                state_d = ST_FIN;
            end
            ST_FIN: begin
                // Returning to IDLE here means a req seen this cycle is dropped.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode straight from the state register so reset kills ram_we at once.
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign err      = (state_q == ST_FIN) & err_q;
    assign ram_we   = (state_q == ST_WR);
    assign ram_addr = {addr_q[31:2], 2'b00};
    assign ram_din  = merge_data;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl with a behavioural RAM and
// an arithmetic reference model of loads, stores, errors and latency.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we_in = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, ram_we;
    logic [31:0] rdata, ram_addr, ram_din, ram_dout;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        preload = 1'b0;
    logic [31:0] exp_rdata;
    int          n_checks = 0;
    int          n_errors = 0;
    int          txn_id = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .DEPTH_WORDS (64),
        .LITTLE_END  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we_in    (we_in),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    // Behavioural RAM: combinational read, write on the clock edge.
    always_comb ram_dout = (ram_addr[31:8] == 24'h0) ? mem[ram_addr[7:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (ram_we && (ram_addr[31:8] == 24'h0)) begin
            mem[ram_addr[7:2]] <= ram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request through the DUT, checked against the reference model.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input bit hold);
        logic        fault;
        int          exp_lat, exp_wr, shamt;
        logic [31:0] old_word, new_word, lanemask, ldval;
        logic        msb;
        int          dcyc, wcnt, wcyc;
        logic [31:0] din_seen, addr_seen, rd_seen;
        logic        err_seen, busy_ok;

        fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
        exp_lat  = fault ? 1 : ((!we || sz == 2'b10) ? 2 : 3);
        exp_wr   = (!fault && we) ? 1 : 0;
        new_word = 32'h0;
        if (!fault) begin
            old_word = ref_mem[a[7:2]];
            shamt    = (sz == 2'b00) ? int'(a[1:0]) * 8 : (sz == 2'b01) ? int'(a[1]) * 16 : 0;
            lanemask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (we) begin
                new_word = (old_word & ~(lanemask << shamt)) | ((wd & lanemask) << shamt);
            end else begin
                ldval = (old_word >> shamt) & lanemask;
                msb   = (sz == 2'b00) ? ldval[7] : ldval[15];
                if (sx && sz != 2'b10 && msb) ldval = ldval | ~lanemask;
                exp_rdata = ldval;
            end
        end

        @(negedge clk);
        check("idle_before", {31'b0, busy}, 32'd0);
        we_in = we; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;

        dcyc = 0; wcnt = 0; wcyc = 0; busy_ok = 1'b1;
        din_seen = 32'h0; addr_seen = 32'h0; rd_seen = 32'hX; err_seen = 1'bX;
        for (int c = 1; c <= 8 && dcyc == 0; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (ram_we) begin
                wcnt++;
                wcyc = c;
                din_seen = ram_din;
                addr_seen = ram_addr;
            end
            if (done) begin
                dcyc = c;
                err_seen = err;
                rd_seen = rdata;
                req = 1'b0;
            end
        end

        check("done_cycle", dcyc, exp_lat);
        check("err", {31'b0, err_seen}, {31'b0, fault});
        check("write_count", wcnt, exp_wr);
        check("busy_during", {31'b0, busy_ok}, 32'd1);
        check("rdata", rd_seen, exp_rdata);
        if (exp_wr == 1) begin
            check("write_cycle", wcyc, exp_lat - 1);
            check("ram_din", din_seen, new_word);
            check("ram_addr", addr_seen, {a[31:2], 2'b00});
            ref_mem[a[7:2]] = new_word;
        end

        // A req held through FIN must not have been accepted.
        @(negedge clk);
        check("idle_after", {31'b0, busy}, 32'd0);
        check("done_pulse", {31'b0, done}, 32'd0);
        if (a[31:8] == 24'h0) check("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);

        $display("txn %0d we=%0d size=%0d sx=%0d addr=%h wdata=%h hold=%0d -> done@%0d err=%0d rdata=%h writes=%0d",
                 txn_id, we, sz, sx, a, wd, hold, dcyc, err_seen, rd_seen, wcnt);
        txn_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rsz;
        logic [31:0] raddr;
        int          r;

        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h0000_0002;
        ref_mem[2] = 32'h80FF_7F03;
        exp_rdata  = 32'h0;

        rst_n = 1'b0;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_din", ram_din, 32'h0);

        @(negedge clk) rst_n = 1'b1;

        // Directed cases.
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0, 1'b0);
        check("dir_lb_sext", rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0, 1'b0);
        check("dir_lh_zext", rdata, 32'h0000_80FF);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        check("dir_lw", rdata, 32'h0000_0002);
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'h0000_00AA, 1'b0);
        check("dir_sb_mem", mem[2], 32'h80FF_AA03);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
        check("dir_lw_after_sb", rdata, 32'h80FF_AA03);
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_1234, 1'b0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_BEEF, 1'b1);

        // Reset asserted while the store is in its write cycle.
        @(negedge clk);
        we_in = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h0000_000D; wdata = 32'h55; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2;
        check("wr_before_rst", {31'b0, ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_rdata", rdata, 32'h0);
        exp_rdata = 32'h0;
        @(posedge clk);
        #1 check("rst_mid_mem", mem[3], ref_mem[3]);
        @(negedge clk) rst_n = 1'b1;
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            rsz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            raddr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 'h10F));
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'b01) raddr[0] = 1'b0;
                if (rsz == 2'b10) raddr[1:0] = 2'b00;
            end
            run_txn(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), raddr,
                    $urandom, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
